// File: rtl/jam_phase_sequencer_if.sv
// Bundle of traffic-side signals between jam_phase_sequencer and its environment.
// master: the sequencer, which drives the jam controls.
// slave: the environment, which drives the jam flags and the normal-controller yield.
interface jam_phase_sequencer_if;
  logic [3:0] traffic_jam;
  logic       normal_idle;
  logic       jam_mode;
  logic       jam_opp_en;
  logic       jam_start;
  logic       jam_rotation;
  logic       jam_yellow;
  logic [2:0] seq_state;

  modport master (
    input  traffic_jam,
    input  normal_idle,
    output jam_mode,
    output jam_opp_en,
    output jam_start,
    output jam_rotation,
    output jam_yellow,
    output seq_state
  );

  modport slave (
    output traffic_jam,
    output normal_idle,
    input  jam_mode,
    input  jam_opp_en,
    input  jam_start,
    input  jam_rotation,
    input  jam_yellow,
    input  seq_state
  );
endinterface

// File: rtl/jam_phase_sequencer.sv
// jam_phase_sequencer: qualifies persistent lane jams, takes the intersection
// over from the normal controller, steps green time between jammed lanes
// (green -> yellow -> rotate) and hands control back once the jams clear.
// Optional feature macro: JAM_SEQ_ROUND_LIMIT_EN -- when defined, jam mode is
// released after 4*MAX_ROUNDS rotations even if jams persist.
// All outputs come straight from flops; each state lasts its parameter count
// because the phase counter restarts at 0 on every state change and compares
// against parameter-1.
module jam_phase_sequencer #(
  parameter int GREEN_CYCLES  = 16,
  parameter int YELLOW_CYCLES = 4,
  parameter int ENTRY_HOLD    = 8,
  parameter int EXIT_HOLD     = 8,
  parameter int MAX_ROUNDS    = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jam_phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUAL     = 3'd1,
    ST_HANDOVER = 3'd2,
    ST_START    = 3'd3,
    ST_GREEN    = 3'd4,
    ST_YELLOW   = 3'd5,
    ST_ROTATE   = 3'd6,
    ST_RELEASE  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST  = CNT_W'(ENTRY_HOLD - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(EXIT_HOLD - 1);
  localparam logic [CNT_W-1:0] QUIET_MAX   = CNT_W'(EXIT_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic             exit_q, exit_d;

  logic jam_mode_q, jam_mode_d;
  logic opp_en_q, opp_en_d;
  logic start_q, start_d;
  logic rotation_q, rotation_d;
  logic yellow_q, yellow_d;

  logic jam_any;
  logic quiet_hit;
  logic limit_hit;

  assign jam_any = |bus.traffic_jam;
  // This cycle's jam-free sample brings the quiet run up to EXIT_HOLD.
  assign quiet_hit = !jam_any && (quiet_q >= QUIET_LAST);

`ifdef JAM_SEQ_ROUND_LIMIT_EN
  localparam int ROT_W = CNT_W + 3;
  localparam logic [ROT_W-1:0] ROUND_LIMIT = ROT_W'(4 * MAX_ROUNDS);

  logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;

  // Rotation counter: one step per ROTATE entry, held at the limit, cleared in IDLE.
  always_comb begin
    rot_cnt_d = rot_cnt_q;
    if (state_q == ST_IDLE) begin
      rot_cnt_d = '0;
    end else if ((state_d == ST_ROTATE) && (rot_cnt_q < ROUND_LIMIT)) begin
      rot_cnt_d = rot_cnt_q + ROT_W'(1);
    end
  end

  // Rotation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_cnt_q <= '0;
    end else begin
      rot_cnt_q <= rot_cnt_d;
    end
  end

  assign limit_hit = (rot_cnt_q >= ROUND_LIMIT);
`else
  logic unused_max_rounds;
  assign unused_max_rounds = ^MAX_ROUNDS;
  assign limit_hit         = 1'b0;
`endif

  // Next-state, phase counter and exit flag.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    exit_d  = exit_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        exit_d  = 1'b0;
        if (jam_any) begin
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (!jam_any) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (phase_q == ENTRY_LAST) begin
          state_d = ST_HANDOVER;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      ST_HANDOVER: begin
        // A vanished jam wins over a late yield from the normal controller.
        if (!jam_any) begin
          state_d = ST_IDLE;
        end else if (bus.normal_idle) begin
          state_d = ST_START;
        end
        phase_d = '0;
      end
      ST_START: begin
        state_d = ST_GREEN;
        phase_d = '0;
      end
      ST_GREEN: begin
        if (quiet_hit) begin
          state_d = ST_YELLOW;
          phase_d = '0;
          exit_d  = 1'b1;
        end else if (phase_q == GREEN_LAST) begin
          state_d = ST_YELLOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      ST_YELLOW: begin
        // Once the exit decision is latched a returning jam cannot cancel it.
        if (phase_q == YELLOW_LAST) begin
          phase_d = '0;
          state_d = (exit_q || limit_hit) ? ST_RELEASE : ST_ROTATE;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      ST_ROTATE: begin
        state_d = ST_GREEN;
        phase_d = '0;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        phase_d = '0;
        exit_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        exit_d  = 1'b0;
      end
    endcase
  end

  // Quiet counter: consecutive jam-free cycles while the allocation logic is enabled.
  always_comb begin
    quiet_d = '0;
    if (opp_en_q && !jam_any) begin
      quiet_d = (quiet_q >= QUIET_MAX) ? QUIET_MAX : (quiet_q + CNT_ONE);
    end
  end

  // Output decode from the next state so the flops present them with their state.
  always_comb begin
    jam_mode_d = state_d inside {ST_HANDOVER, ST_START, ST_GREEN, ST_YELLOW, ST_ROTATE};
    opp_en_d   = state_d inside {ST_START, ST_GREEN, ST_YELLOW, ST_ROTATE};
    start_d    = (state_d == ST_START);
    rotation_d = (state_d == ST_ROTATE);
    yellow_d   = (state_d == ST_YELLOW);
  end

  // State, counters and registered outputs; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      quiet_q    <= '0;
      exit_q     <= 1'b0;
      jam_mode_q <= 1'b0;
      opp_en_q   <= 1'b0;
      start_q    <= 1'b0;
      rotation_q <= 1'b0;
      yellow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      quiet_q    <= quiet_d;
      exit_q     <= exit_d;
      jam_mode_q <= jam_mode_d;
      opp_en_q   <= opp_en_d;
      start_q    <= start_d;
      rotation_q <= rotation_d;
      yellow_q   <= yellow_d;
    end
  end

  assign bus.jam_mode     = jam_mode_q;
  assign bus.jam_opp_en   = opp_en_q;
  assign bus.jam_start    = start_q;
  assign bus.jam_rotation = rotation_q;
  assign bus.jam_yellow   = yellow_q;
  assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_jam_phase_sequencer.sv
// Directed bench for jam_phase_sequencer: every cycle the full output vector
// {jam_mode, jam_opp_en, jam_start, jam_rotation, jam_yellow, seq_state} is
// compared against a hand-derived expected state, sampled 1 time unit after
// the rising edge. Edge numbers count rising edges after reset release.
module tb_jam_phase_sequencer;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_QUAL     = 3'd1;
  localparam logic [2:0] S_HANDOVER = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_GREEN    = 3'd4;
  localparam logic [2:0] S_YELLOW   = 3'd5;
  localparam logic [2:0] S_ROTATE   = 3'd6;
  localparam logic [2:0] S_RELEASE  = 3'd7;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  jam_phase_sequencer_if bus_if ();

  jam_phase_sequencer #(
    .GREEN_CYCLES (16),
    .YELLOW_CYCLES(4),
    .ENTRY_HOLD   (8),
    .EXIT_HOLD    (8),
    .MAX_ROUNDS   (1),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Expected output vector for a given state.
  function automatic logic [7:0] exp_outs(input logic [2:0] st);
    logic mode, opp, start, rot, yel;
    mode  = (st >= S_HANDOVER) && (st <= S_ROTATE);
    opp   = (st >= S_START) && (st <= S_ROTATE);
    start = (st == S_START);
    rot   = (st == S_ROTATE);
    yel   = (st == S_YELLOW);
    return {mode, opp, start, rot, yel, st};
  endfunction

  function automatic logic [7:0] obs_outs();
    return {bus_if.jam_mode, bus_if.jam_opp_en, bus_if.jam_start,
            bus_if.jam_rotation, bus_if.jam_yellow, bus_if.seq_state};
  endfunction

  // Expected state at edge e after reset release, jam held and normal_idle=1.
  function automatic logic [2:0] model_cont(input int e);
    int p;
    if (e <= 8)  return S_QUAL;
    if (e == 9)  return S_HANDOVER;
    if (e == 10) return S_START;
`ifdef JAM_SEQ_ROUND_LIMIT_EN
    // Rotations at 31, 52, 73, 94; the yellow after the 4th ends at edge 115.
    if (e == 115) return S_RELEASE;
    if (e == 116) return S_IDLE;
    if (e >= 117) return S_QUAL;
`endif
    p = (e - 11) % 21;
    if (p < 16) return S_GREEN;
    if (p < 20) return S_YELLOW;
    return S_ROTATE;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_exp(input string tag, input logic [2:0] st);
    tick();
    check_eq(tag, {24'd0, obs_outs()}, {24'd0, exp_outs(st)});
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, then released.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_eq(tag, {24'd0, obs_outs()}, 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    bus_if.traffic_jam = 4'b0100;
    bus_if.normal_idle = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with a jam present: outputs quiet.
    tick();
    tick();
    check_eq("reset_outs", {24'd0, obs_outs()}, 32'd0);
    check_eq("reset_state", {29'd0, bus_if.seq_state}, {29'd0, S_IDLE});
    #5 rst_n = 1'b1;

    // Continuous jam: qualify, handover, start at edge 10, rotate every 21.
    for (int e = 1; e <= 80; e++) begin
      step_exp($sformatf("cont e=%0d", e), model_cont(e));
    end
    $display("phase cont: edges 1..80 checked, bad so far=%0d", n_bad);

    // Jam clears mid-GREEN after edge 80: yellow at 88, release 92, idle 93.
    // The jam returning during the exit yellow must not cancel the release.
    bus_if.traffic_jam = 4'b0000;
    for (int e = 81; e <= 94; e++) begin
      logic [2:0] st;
      if (e < 88)       st = S_GREEN;
      else if (e < 92)  st = S_YELLOW;
      else if (e == 92) st = S_RELEASE;
      else if (e == 93) st = S_IDLE;
      else              st = S_QUAL;
      step_exp($sformatf("quiet e=%0d", e), st);
      if (e == 89) bus_if.traffic_jam = 4'b1000;
    end
    bus_if.traffic_jam = 4'b0000;
    step_exp("requal_drop", S_IDLE);
    $display("phase quiet exit: bad so far=%0d", n_bad);

    // Short jam pulse (5 cycles) never reaches handover.
    bus_if.traffic_jam = 4'b0001;
    for (int i = 1; i <= 5; i++) step_exp($sformatf("pulse i=%0d", i), S_QUAL);
    bus_if.traffic_jam = 4'b0000;
    step_exp("pulse_end", S_IDLE);
    step_exp("pulse_idle", S_IDLE);
    $display("phase pulse: bad so far=%0d", n_bad);

    // Handover held off by normal_idle=0, then aborted by the jam vanishing.
    bus_if.normal_idle = 1'b0;
    bus_if.traffic_jam = 4'b0011;
    for (int i = 1; i <= 8; i++) step_exp($sformatf("hold_q i=%0d", i), S_QUAL);
    for (int i = 0; i <= 20; i++) step_exp($sformatf("hold_h i=%0d", i), S_HANDOVER);
    bus_if.traffic_jam = 4'b0000;
    step_exp("hold_abort", S_IDLE);

    // Requalify, wait in HANDOVER, start one cycle after normal_idle rises.
    bus_if.traffic_jam = 4'b0011;
    for (int i = 1; i <= 8; i++) step_exp($sformatf("req_q i=%0d", i), S_QUAL);
    for (int i = 0; i <= 2; i++) step_exp($sformatf("req_h i=%0d", i), S_HANDOVER);
    bus_if.normal_idle = 1'b1;
    step_exp("req_start", S_START);
    for (int i = 0; i < 16; i++) step_exp($sformatf("req_g i=%0d", i), S_GREEN);
    step_exp("req_y0", S_YELLOW);
    step_exp("req_y1", S_YELLOW);
    pulse_reset("reset_mid_yellow");
    $display("phase handover: bad so far=%0d", n_bad);

    // Long continuous jam: round limit releases when enabled, otherwise keeps rotating.
    for (int e = 1; e <= 117; e++) begin
      step_exp($sformatf("long e=%0d", e), model_cont(e));
    end
    $display("phase long: bad so far=%0d", n_bad);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/jam_phase_sequencer.md
# jam_phase_sequencer

Sequencer that drives the jam-opportunity allocation logic. It qualifies persistent traffic jams, takes the intersection over from the normal signal controller through a handover handshake, and then generates the `jam_opp_en`, `jam_start` and `jam_rotation` controls that step green time between jammed lanes. Each green is followed by a yellow interval. When the jams clear, control returns to the normal controller.

## Interface
- `GREEN_CYCLES`, 16: cycles of each jam-lane green.
- `YELLOW_CYCLES`, 4: cycles of each all-stop yellow.
- `ENTRY_HOLD`, 8: consecutive cycles a jam must persist before takeover.
- `EXIT_HOLD`, 8: consecutive jam-free cycles that trigger release.
- `MAX_ROUNDS`, 4: rotation limit, used only with the macro enabled.
- `CNT_W`, 8: width of all counters. Every cycle parameter must be ≥1 and < 2^CNT_W.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `traffic_jam` in 4: per-lane jam flags; bit i is lane i.
- `normal_idle` in 1: the normal controller is at all-red and has yielded.
- `jam_mode` out 1: request/hold for takeover, sent to the normal controller.
- `jam_opp_en` out 1: enable for the allocation logic.
- `jam_start` out 1: one-cycle pulse that selects the first jammed lane.
- `jam_rotation` out 1: one-cycle pulse that advances to the next jammed lane.
- `jam_yellow` out 1: yellow interval active; all allowed lanes show yellow.
- `seq_state` out 3: encoded state, for debug.

## Operation
- `jam_any` = OR of `traffic_jam`.
- States and their `seq_state` encodings: IDLE=0, QUAL=1, HANDOVER=2, START=3, GREEN=4, YELLOW=5, ROTATE=6, RELEASE=7.
- **IDLE**: go to QUAL when `jam_any`=1. The phase counter is cleared.
- **QUAL**:
  - If `jam_any`=0, return to IDLE.
  - Otherwise, after `jam_any` has been high for `ENTRY_HOLD` consecutive cycles (counting the IDLE exit cycle), go to HANDOVER.
- **HANDOVER**:
  - `jam_mode`=1.
  - Wait for `normal_idle`=1, then go to START.
  - If `jam_any` drops before that, go to IDLE and deassert `jam_mode`.
- **START**: `jam_opp_en`=1 and `jam_start`=1 for exactly one cycle, then go to GREEN.
- **GREEN**:
  - Lasts `GREEN_CYCLES` cycles, then go to YELLOW.
  - If the quiet counter reaches `EXIT_HOLD`, go to YELLOW early and set the exit flag.
- **YELLOW**: `jam_yellow`=1 for `YELLOW_CYCLES` cycles. At the end:
  - exit flag set → RELEASE;
  - otherwise → ROTATE.
- **ROTATE**: `jam_rotation`=1 for one cycle, then go to GREEN with the phase counter cleared.
- **RELEASE**: `jam_opp_en`=0 and `jam_mode`=0 for one cycle, then go to IDLE. The exit flag is cleared.
- `jam_opp_en`=1 in states START through ROTATE.
- `jam_mode`=1 in states HANDOVER through ROTATE.
- Quiet counter:
  - Counts consecutive `jam_any`=0 cycles while `jam_opp_en`=1.
  - Clears on any `jam_any`=1.
  - Saturates at `EXIT_HOLD`.
- `normal_idle` is ignored outside HANDOVER.
- A jam that reasserts during the exit YELLOW does not cancel the release. Requalification through QUAL is required.
- All outputs are registered and glitch-free.

## Timing
- Reset values: all outputs are 0 and `seq_state`=IDLE. Reset is honoured in any state, including mid-GREEN; outputs drop asynchronously.
- Minimum latency from a `jam_any` rise to `jam_start`: `ENTRY_HOLD`+2 cycles, when `normal_idle` is already high.
- `jam_start` and `jam_rotation` are never high together, and never high while `jam_yellow`=1.
- Every GREEN is preceded by exactly one `jam_start` or `jam_rotation` pulse.
- Full-rotation GREEN→YELLOW→ROTATE period: `GREEN_CYCLES`+`YELLOW_CYCLES`+1.
- Counters compare against parameter−1 and wrap to 0 on a state change. There is no overflow path.

## Configuration
- `JAM_SEQ_ROUND_LIMIT_EN` defined:
  - A rotation counter increments on each ROTATE pulse.
  - When it reaches 4×`MAX_ROUNDS`, the next YELLOW end goes to RELEASE regardless of `jam_any`.
  - The counter clears in IDLE.
- `JAM_SEQ_ROUND_LIMIT_EN` not defined: there is no rotation counter and jam mode persists until the quiet exit.

## Test plan
- Reset with `traffic_jam`=4'b0100:
  - all outputs are 0;
  - after release, `jam_start` occurs at cycle 10 with `normal_idle`=1 and default parameters.
- Jam pulse of 5 cycles (< `ENTRY_HOLD`) → QUAL→IDLE with no `jam_mode`.
- Persistent jam with `normal_idle` held 0 for 20 cycles → `jam_mode`=1 throughout, no `jam_start`. `jam_start` follows 1 cycle after `normal_idle` rises.
- Continuous jam → `jam_rotation` pulses every 21 cycles, each preceded by 4 cycles of `jam_yellow`.
- Jam clears mid-GREEN → 8 cycles later, YELLOW (4 cycles), then RELEASE: `jam_opp_en`/`jam_mode` low, then IDLE.
- With the macro defined and `MAX_ROUNDS`=1, continuous jam → after the 4th rotation, the following yellow leads to RELEASE. Additionally, `rst_n` asserted mid-YELLOW → outputs 0 immediately.
